// File: rtl/dma_stream_device.sv
// dma_stream_device
//   Clocked DMA source device. It refills DEPTH entries of WORDS_PER_ENTRY
//   words from a 32-bit Galois LFSR, waits FIRE_CYCLES, raises an interrupt
//   to request a DMA transfer, and serves registered reads by entry offset.
//   This repeats for NUM_BURSTS bursts (0 = forever), then it halts.
//
// Ports
//   clk        : rising-edge clock
//   reset_n    : synchronous active-low reset
//   offset     : entry index to read
//   rd_en      : read request, sampled every cycle
//   xfer_done  : one-cycle end-of-transfer pulse from the DMA controller
//   int_ack    : interrupt acknowledge (only with DEV_INT_ACK_EN)
//   data       : registered read data, word 0 in the LSBs
//   data_valid : data holds a valid entry this cycle
//   rd_err     : one-cycle pulse marking a rejected read
//   interrupt  : DMA request to the CPU
//   busy       : high while the storage is being refilled
//
// Optional build macro
//   DEV_INT_ACK_EN : the interrupt is held until int_ack is sampled high,
//                    instead of lasting a fixed INT_CYCLES.
module dma_stream_device #(
    parameter int          WORD_SIZE       = 16,
    parameter int          WORDS_PER_ENTRY = 4,
    parameter int          DEPTH           = 3,
    parameter int          FIRE_CYCLES     = 2000,
    parameter int          INT_CYCLES      = 20,
    parameter int          NUM_BURSTS      = 2,
    parameter logic [31:0] SEED            = 32'hACE1_2468,
    localparam int         OFF_W           = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                                 clk,
    input  logic                                 reset_n,
    input  logic [OFF_W-1:0]                     offset,
    input  logic                                 rd_en,
    input  logic                                 xfer_done,
`ifdef DEV_INT_ACK_EN
    input  logic                                 int_ack,
`endif
    output logic [WORDS_PER_ENTRY*WORD_SIZE-1:0] data,
    output logic                                 data_valid,
    output logic                                 rd_err,
    output logic                                 interrupt,
    output logic                                 busy
);

    localparam int DATA_W = WORDS_PER_ENTRY * WORD_SIZE;
    localparam int WI_W   = (WORDS_PER_ENTRY > 1) ? $clog2(WORDS_PER_ENTRY) : 1;

    typedef enum logic [2:0] {
        ST_REFILL = 3'd0,
        ST_COUNT  = 3'd1,
        ST_FIRE   = 3'd2,
        ST_WAIT   = 3'd3,
        ST_HALT   = 3'd4
    } state_t;

    // Galois step for x^32 + x^22 + x^2 + x + 1 (right-shifting form).
    function automatic logic [31:0] lfsr_step(input logic [31:0] cur);
        logic [31:0] nxt;
        nxt = {1'b0, cur[31:1]};
        if (cur[0]) begin
            nxt = nxt ^ 32'h8020_0003;
        end else begin
            nxt = nxt;
        end
        return nxt;
    endfunction

    state_t              state_r, state_s;
    logic [31:0]         timer_r, timer_s;
    logic [31:0]         bursts_r, bursts_s;
    logic [31:0]         lfsr_r, lfsr_s;
    logic [OFF_W-1:0]    fill_entry_r, fill_entry_s;
    logic [WI_W-1:0]     fill_word_r, fill_word_s;
    logic                interrupt_r, interrupt_s;
    logic                busy_r;
    logic                wr_en_s;
    logic                fire_end_s;
    logic                last_burst_s;

    logic [WORD_SIZE-1:0] mem_r [DEPTH][WORDS_PER_ENTRY];
    logic [DATA_W-1:0]    data_r, rd_entry_s;
    logic                 data_valid_r, rd_err_r, rd_ok_s;

    // Next-state and next-output logic of the refill/count/fire/wait FSM.
    always_comb begin
        state_s      = state_r;
        timer_s      = timer_r;
        bursts_s     = bursts_r;
        lfsr_s       = lfsr_r;
        fill_entry_s = fill_entry_r;
        fill_word_s  = fill_word_r;
        interrupt_s  = interrupt_r;
        wr_en_s      = 1'b0;
`ifdef DEV_INT_ACK_EN
        fire_end_s   = int_ack;
`else
        fire_end_s   = (timer_r == 32'(INT_CYCLES - 1));
`endif
        // The burst completing now is the last one when the count would reach the limit.
        last_burst_s = (NUM_BURSTS != 0) && ((bursts_r + 32'd1) >= 32'(NUM_BURSTS));
        case (state_r)
            ST_REFILL: begin
                wr_en_s     = 1'b1;
                lfsr_s      = lfsr_step(lfsr_r);
                interrupt_s = 1'b0;
                if (fill_word_r == WI_W'(WORDS_PER_ENTRY - 1)) begin
                    fill_word_s = {WI_W{1'b0}};
                    if (fill_entry_r == OFF_W'(DEPTH - 1)) begin
                        fill_entry_s = {OFF_W{1'b0}};
                        timer_s      = 32'd0;
                        state_s      = ST_COUNT;
                    end else begin
                        fill_entry_s = fill_entry_r + OFF_W'(1);
                    end
                end else begin
                    fill_word_s = fill_word_r + WI_W'(1);
                end
            end
            ST_COUNT: begin
                // xfer_done is deliberately ignored here, even on the expiry edge.
                if (timer_r == 32'(FIRE_CYCLES - 1)) begin
                    timer_s     = 32'd0;
                    interrupt_s = 1'b1;
                    state_s     = ST_FIRE;
                end else begin
                    timer_s = timer_r + 32'd1;
                end
            end
            ST_FIRE: begin
                if (xfer_done) begin
                    interrupt_s  = 1'b0;
                    bursts_s     = bursts_r + 32'd1;
                    fill_entry_s = {OFF_W{1'b0}};
                    fill_word_s  = {WI_W{1'b0}};
                    state_s      = ST_REFILL;
                end else if (fire_end_s) begin
                    interrupt_s = 1'b0;
                    timer_s     = 32'd0;
                    state_s     = ST_WAIT;
                end else begin
                    timer_s = timer_r + 32'd1;
                end
            end
            ST_WAIT: begin
                interrupt_s = 1'b0;
                if (xfer_done) begin
                    bursts_s = bursts_r + 32'd1;
                    if (last_burst_s) begin
                        state_s = ST_HALT;
                    end else begin
                        fill_entry_s = {OFF_W{1'b0}};
                        fill_word_s  = {WI_W{1'b0}};
                        state_s      = ST_REFILL;
                    end
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_HALT: begin
                interrupt_s = 1'b0;
            end
            default: begin
                interrupt_s  = 1'b0;
                fill_entry_s = {OFF_W{1'b0}};
                fill_word_s  = {WI_W{1'b0}};
                state_s      = ST_REFILL;
            end
        endcase
    end

    // FSM state, counters, LFSR and the interrupt/busy output registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r      <= ST_REFILL;
            timer_r      <= 32'd0;
            bursts_r     <= 32'd0;
            lfsr_r       <= SEED;
            fill_entry_r <= {OFF_W{1'b0}};
            fill_word_r  <= {WI_W{1'b0}};
            interrupt_r  <= 1'b0;
            busy_r       <= 1'b1;
        end else begin
            state_r      <= state_s;
            timer_r      <= timer_s;
            bursts_r     <= bursts_s;
            lfsr_r       <= lfsr_s;
            fill_entry_r <= fill_entry_s;
            fill_word_r  <= fill_word_s;
            interrupt_r  <= interrupt_s;
            busy_r       <= (state_s == ST_REFILL);
        end
    end

    // Entry storage; each refill cycle writes the freshly shifted LFSR word.
    always_ff @(posedge clk) begin
        if (reset_n && wr_en_s) begin
            mem_r[fill_entry_r][fill_word_r] <= lfsr_s[WORD_SIZE-1:0];
        end
    end

    // Read qualification and entry assembly (word 0 in the LSBs).
    always_comb begin
        rd_entry_s = {DATA_W{1'b0}};
        rd_ok_s    = rd_en && (state_r != ST_REFILL) && (32'(offset) < 32'(DEPTH));
        if (rd_ok_s) begin
            for (int w = 0; w < WORDS_PER_ENTRY; w++) begin
                rd_entry_s[w*WORD_SIZE +: WORD_SIZE] = mem_r[offset][w];
            end
        end else begin
            rd_entry_s = {DATA_W{1'b0}};
        end
    end

    // Registered read port; an idle cycle keeps the last data word.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            data_r       <= {DATA_W{1'b0}};
            data_valid_r <= 1'b0;
            rd_err_r     <= 1'b0;
        end else if (rd_en) begin
            data_r       <= rd_entry_s;
            data_valid_r <= rd_ok_s;
            rd_err_r     <= !rd_ok_s;
        end else begin
            data_valid_r <= 1'b0;
            rd_err_r     <= 1'b0;
        end
    end

    assign data       = data_r;
    assign data_valid = data_valid_r;
    assign rd_err     = rd_err_r;
    assign interrupt  = interrupt_r;
    assign busy       = busy_r;

endmodule

// File: tb/tb_dma_stream_device.sv
// Self-checking bench for dma_stream_device. A phase/duration model with a
// precomputed LFSR word list predicts every output each cycle; directed
// checks pin the timing and the first entry to hand-computed constants.
module tb_dma_stream_device;

    localparam int          WS     = 16;
    localparam int          WPE    = 4;
    localparam int          DEPTH  = 3;
    localparam int          FIRE   = 10;
    localparam int          INTC   = 4;
    localparam int          NB     = 2;
    localparam int          DW     = WS * WPE;
    localparam int          NWORDS = DEPTH * WPE;
    localparam int          GBANKS = 64;
    localparam logic [31:0] SEED   = 32'hACE1_2468;
    localparam logic [31:0] TAPS   = (32'd1 << 31) | (32'd1 << 21) | (32'd1 << 1) | 32'd1;

    localparam int PH_REFILL = 0;
    localparam int PH_COUNT  = 1;
    localparam int PH_FIRE   = 2;
    localparam int PH_WAIT   = 3;
    localparam int PH_HALT   = 4;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [1:0]    offset;
    logic          rd_en;
    logic          xfer_done;
`ifdef DEV_INT_ACK_EN
    logic          int_ack;
`endif
    logic [DW-1:0] data;
    logic          data_valid;
    logic          rd_err;
    logic          interrupt;
    logic          busy;

    always #5 clk = ~clk;

    dma_stream_device #(
        .WORD_SIZE      (WS),
        .WORDS_PER_ENTRY(WPE),
        .DEPTH          (DEPTH),
        .FIRE_CYCLES    (FIRE),
        .INT_CYCLES     (INTC),
        .NUM_BURSTS     (NB),
        .SEED           (SEED)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .offset    (offset),
        .rd_en     (rd_en),
        .xfer_done (xfer_done),
`ifdef DEV_INT_ACK_EN
        .int_ack   (int_ack),
`endif
        .data      (data),
        .data_valid(data_valid),
        .rd_err    (rd_err),
        .interrupt (interrupt),
        .busy      (busy)
    );

    int checks = 0;
    int errors = 0;

    logic [WS-1:0] gold [NWORDS*GBANKS];
    int            m_phase, m_age, m_bank, m_bursts;
    logic [DW-1:0] m_data;
    logic          m_valid, m_err;
    bit            chk_en = 1'b0;
    bit            rnd_rd = 1'b0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h at %0t", name, got, exp, $time);
        end
    endtask

    // Entry `off` of the refill numbered `bank` since the last reset.
    function automatic logic [DW-1:0] entry_of(input int bank, input int off);
        logic [DW-1:0] e;
        e = '0;
        if (bank < GBANKS) begin
            for (int w = 0; w < WPE; w++) e[w*WS +: WS] = gold[bank*NWORDS + off*WPE + w];
        end
        return e;
    endfunction

    task automatic start_refill();
        m_phase = PH_REFILL;
        m_age   = 0;
        m_bank  = m_bank + 1;
    endtask

    // Advance the model across one clock edge using the inputs seen at it.
    task automatic model_edge();
        if (!reset_n) begin
            m_phase = PH_REFILL; m_age = 0; m_bank = 0; m_bursts = 0;
            m_data = '0; m_valid = 1'b0; m_err = 1'b0;
        end else begin
            if (rd_en) begin
                if (m_phase != PH_REFILL && int'(offset) < DEPTH) begin
                    m_data = entry_of(m_bank, int'(offset)); m_valid = 1'b1; m_err = 1'b0;
                end else begin
                    m_data = '0; m_valid = 1'b0; m_err = 1'b1;
                end
            end else begin
                m_valid = 1'b0; m_err = 1'b0;
            end
            case (m_phase)
                PH_REFILL: begin
                    m_age++;
                    if (m_age == NWORDS) begin m_phase = PH_COUNT; m_age = 0; end
                end
                PH_COUNT: begin
                    m_age++;
                    if (m_age == FIRE) begin m_phase = PH_FIRE; m_age = 0; end
                end
                PH_FIRE: begin
                    if (xfer_done) begin
                        m_bursts++;
                        start_refill();
                    end else begin
                        m_age++;
`ifdef DEV_INT_ACK_EN
                        if (int_ack) m_phase = PH_WAIT;
`else
                        if (m_age == INTC) m_phase = PH_WAIT;
`endif
                    end
                end
                PH_WAIT: begin
                    if (xfer_done) begin
                        m_bursts++;
                        if (m_bursts >= NB) m_phase = PH_HALT;
                        else start_refill();
                    end
                end
                default: ;
            endcase
        end
    endtask

    task automatic cycle();
        if (rnd_rd) begin
            rd_en  = ($urandom_range(0, 1) == 1);
            offset = 2'($urandom_range(0, 3));
        end
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic wait_int(input int budget);
        for (int i = 0; i < budget && !interrupt; i++) cycle();
        check("wait_int", 64'(interrupt), 64'd1);
    endtask

    task automatic to_wait();
`ifdef DEV_INT_ACK_EN
        int_ack = 1'b1; cycle(); int_ack = 1'b0;
`else
        for (int i = 0; i < 50 && interrupt; i++) cycle();
`endif
        check("to_wait", 64'(interrupt), 64'd0);
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("data", 64'(data), 64'(m_data));
            check("data_valid", 64'(data_valid), 64'(m_valid));
            check("rd_err", 64'(rd_err), 64'(m_err));
            check("interrupt", 64'(interrupt), 64'(m_phase == PH_FIRE));
            check("busy", 64'(busy), 64'(m_phase == PH_REFILL));
        end
    end

    initial begin
        logic [31:0]   s;
        logic [DW-1:0] d0;
        int            edges, busy_len, rise, cnt;

        s = SEED;
        for (int n = 0; n < NWORDS*GBANKS; n++) begin
            if (s[0]) s = (s >> 1) ^ TAPS;
            else      s = s >> 1;
            gold[n] = s[WS-1:0];
        end

        reset_n = 1'b0; rd_en = 1'b0; xfer_done = 1'b0; offset = 2'd0;
`ifdef DEV_INT_ACK_EN
        int_ack = 1'b0;
`endif
        cycle();
        chk_en = 1'b1;
        cycle();
        check("rst_data", 64'(data), 64'd0);
        check("rst_valid", 64'(data_valid), 64'd0);
        check("rst_err", 64'(rd_err), 64'd0);
        check("rst_int", 64'(interrupt), 64'd0);
        check("rst_busy", 64'(busy), 64'd1);
        check("gold_entry0", 64'(entry_of(0, 0)), 64'h1245_248D_491A_9234);

        // Fire timing from reset release.
        reset_n = 1'b1;
        edges = 0; busy_len = 0; rise = 0;
        while (rise == 0 && edges < 100) begin
            cycle(); edges++;
            if (!busy && busy_len == 0) busy_len = edges;
            if (interrupt) rise = edges;
        end
        check("busy_len", 64'(busy_len), 64'd12);
        check("int_rise", 64'(rise), 64'd22);
`ifdef DEV_INT_ACK_EN
        cnt = 0;
        repeat (50) begin cycle(); if (interrupt) cnt++; end
        check("ack_hold", 64'(cnt), 64'd50);
        int_ack = 1'b1; cycle(); int_ack = 1'b0;
        check("ack_drop", 64'(interrupt), 64'd0);
`else
        cnt = 1;
        while (interrupt && cnt < 100) begin cycle(); if (interrupt) cnt++; end
        check("int_len", 64'(cnt), 64'd4);
`endif
        cycle();
        check("wait_busy", 64'(busy), 64'd0);
        check("wait_int_low", 64'(interrupt), 64'd0);

        // Read-back of the first refill, then an out-of-range offset.
        d0 = '0;
        for (int k = 0; k < 4; k++) begin
            rd_en = 1'b1; offset = 2'(k); cycle();
            if (k == 0) d0 = data;
        end
        check("rd0_literal", 64'(d0), 64'h1245_248D_491A_9234);
        check("rd3_err", 64'(rd_err), 64'd1);
        check("rd3_data", 64'(data), 64'd0);
        offset = 2'd2; cycle();
        rd_en = 1'b0; cycle();
        check("idle_hold", 64'(data), 64'(entry_of(0, 2)));

        // Read and xfer_done on the same edge: read sees pre-refill data.
        xfer_done = 1'b1; rd_en = 1'b1; offset = 2'd1; cycle();
        xfer_done = 1'b0; rd_en = 1'b0;
        check("sim_rd", 64'(data), 64'(entry_of(0, 1)));
        check("sim_busy", 64'(busy), 64'd1);

        // Second burst with new LFSR words, then halt.
        rnd_rd = 1'b1;
        wait_int(100);
        to_wait();
        rnd_rd = 1'b0; rd_en = 1'b1; offset = 2'd0; cycle(); rd_en = 1'b0;
        check("burst2_rd0", 64'(data), 64'(entry_of(1, 0)));
        xfer_done = 1'b1; cycle(); xfer_done = 1'b0;
        rnd_rd = 1'b1; cnt = 0;
        repeat (5000) begin
            xfer_done = ($urandom_range(0, 49) == 0);
            cycle();
            if (interrupt || busy) cnt++;
        end
        xfer_done = 1'b0; rnd_rd = 1'b0; rd_en = 1'b0;
        check("halt_quiet", 64'(cnt), 64'd0);

        // Early xfer_done in the second cycle of FIRE, then a read in REFILL.
        reset_n = 1'b0; cycle(); reset_n = 1'b1;
        wait_int(100);
        cycle();
        xfer_done = 1'b1; cycle(); xfer_done = 1'b0;
        check("early_int", 64'(interrupt), 64'd0);
        check("early_busy", 64'(busy), 64'd1);
        rd_en = 1'b1; offset = 2'd0; cycle(); rd_en = 1'b0;
        check("refill_err", 64'(rd_err), 64'd1);
        check("refill_valid", 64'(data_valid), 64'd0);

        // Reset during FIRE with a read pending, then reproduce the first data.
        wait_int(100);
        cycle();
        reset_n = 1'b0; rd_en = 1'b1; offset = 2'd1; cycle();
        reset_n = 1'b1; rd_en = 1'b0;
        check("rst_fire_int", 64'(interrupt), 64'd0);
        check("rst_fire_valid", 64'(data_valid), 64'd0);
        check("rst_fire_busy", 64'(busy), 64'd1);
        wait_int(100);
        for (int k = 0; k < 3; k++) begin
            rd_en = 1'b1; offset = 2'(k); cycle();
            if (k == 0) check("rst_rd0_literal", 64'(data), 64'h1245_248D_491A_9234);
        end
        rd_en = 1'b0;

        // Randomized traffic: reads, stray transfer-done pulses, acks.
        rnd_rd = 1'b1;
        repeat (800) begin
            xfer_done = ($urandom_range(0, 15) == 0);
`ifdef DEV_INT_ACK_EN
            int_ack = ($urandom_range(0, 7) == 0);
`endif
            cycle();
        end
        xfer_done = 1'b0;
        rnd_rd = 1'b0;
        rd_en = 1'b0;
        cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
